uart_line_buf: RTL

UART_LINE_BUF -- requirements
Module: uart_line_buf

---
 rtl/uart_line_buf.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_line_buf.sv
`timescale 1ns/1ps
// uart_line_buf -- collects received UART bytes into a line buffer until a
// CR or LF arrives, then holds the line for a consumer to read by address.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   rx_valid, rx_byte            received byte strobe and data
//   start_pulse                  receiver saw a start bit (clears eos)
//   framing_error                bad stop bit on the current byte (aborts line)
//   line_ready, line_len, eos    held-line status
//   rd_addr -> rd_data           registered read port into the buffer
//   line_ack                     consumer releases the held line
//   overflow, err                1-cycle event pulses
module uart_line_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          start_pulse,
  input  logic          framing_error,
  output logic          line_ready,
  output logic [AW:0]   line_len,
  output logic          eos,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          line_ack,
  output logic          overflow,
  output logic          err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {COLLECT, READY, DISCARD} state_t;

  state_t      state;
  logic [AW:0] wr_ptr;
  logic [7:0]  mem [DEPTH];

  logic is_term;
  logic wr_en;
  logic eos_set;

  assign is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);

  // framing_error beats a coincident byte in COLLECT, so it gates both
  assign wr_en   = (state == COLLECT) && rx_valid && !framing_error &&
                   !is_term && (wr_ptr < DEPTH_C);
  assign eos_set = (state == COLLECT) && rx_valid && !framing_error &&
                   is_term && (wr_ptr != '0);

  // Plain synchronous RAM: no reset, read-before-write on address collision
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= 8'h00;
    else       rd_data <= mem[rd_addr];
  end

  // Set has priority over the start-bit clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            eos <= 1'b0;
    else if (eos_set)     eos <= 1'b1;
    else if (start_pulse) eos <= 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= COLLECT;
      wr_ptr     <= '0;
      line_ready <= 1'b0;
      line_len   <= '0;
      overflow   <= 1'b0;
      err        <= 1'b0;
    end else begin
      overflow <= 1'b0;
      err      <= 1'b0;
      case (state)
        COLLECT: begin
          if (framing_error) begin
            err    <= 1'b1;
            wr_ptr <= '0;
            state  <= DISCARD;
          end else if (rx_valid) begin
            if (is_term) begin
              // empty line (e.g. the LF of a CRLF pair) is ignored
              if (wr_ptr != '0) begin
                line_len   <= wr_ptr;
                line_ready <= 1'b1;
                state      <= READY;
              end
            end else if (wr_ptr < DEPTH_C) begin
              wr_ptr <= wr_ptr + 1'b1;
            end else begin
              overflow <= 1'b1;
              state    <= DISCARD;
            end
          end
        end
        READY: begin
          // A terminator trailing the held line carries no payload, so
          // dropping it is not reported as overflow (keeps CRLF silent).
          if (rx_valid && !is_term) overflow <= 1'b1;
          if (line_ack) begin
            line_ready <= 1'b0;
            wr_ptr     <= '0;
            state      <= COLLECT;
          end
        end
        DISCARD: begin
          if (framing_error) begin
            err    <= 1'b1;
            wr_ptr <= '0;
          end else if (rx_valid && is_term) begin
            wr_ptr <= '0;
            state  <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
